mips_dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the MIPS data memory. It shares a single byte-wide data-memory port between the CPU load/store unit (port 0) and a secondary master such as DMA or debug (port 1). Each 32-bit word request is serialized into four byte-beats. Grants alternate round-robin between the ports, and each completed transaction returns an ack, an error flag and assembled read data.

---
 rtl/mips_dmem_arbiter_if.sv | 47 ++++
 rtl/mips_dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mips_dmem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dmem_arbiter_if.sv
// Purpose : bundle of both requester ports and the byte-wide data-memory port of the dmem arbiter.
// Latency : none, wiring only.
// Backpressure: requesters hold reqN until ackN; the memory side has no stall (mem_rdata is combinational).
//
// Ports (signals):
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1   requester -> arbiter
//   ack0/ack1, err0/err1, rdata0/rdata1              arbiter -> requester
//   mem_addr, mem_wdata, mem_we, mem_re              arbiter -> memory
//   mem_rdata                                        memory -> arbiter
// Modports: slave = arbiter side, master = requester/memory side.
interface mips_dmem_arbiter_if #(
    parameter int MEM_ADDR_W = 10
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [31:0]           addr0;
    logic [31:0]           addr1;
    logic [31:0]           wdata0;
    logic [31:0]           wdata1;
    logic                  ack0;
    logic                  ack1;
    logic                  err0;
    logic                  err1;
    logic [31:0]           rdata0;
    logic [31:0]           rdata1;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [7:0]            mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata0, rdata1,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/mips_dmem_arbiter.sv
// Purpose : round-robin arbiter sharing one byte-wide data memory between two word requesters.
// Latency : grant at edge T, byte beats T+1..T+4, ack T+5 (bad address: ack/err at T+1).
// Backpressure: loser waits with req held; winner's later req changes are ignored until ack.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   requester ports 0/1 plus memory port (mips_dmem_arbiter_if.slave)
//   o_busy   high whenever the sequencer is not idle
module mips_dmem_arbiter #(
    parameter int MEM_ADDR_W = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    mips_dmem_arbiter_if.slave io_bus,
    output logic               o_busy
);

    localparam int WORD_W = MEM_ADDR_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_rr;       // port that wins a tie
    logic                r_id;       // port owning the current transaction
    logic                r_we;
    logic                r_err;
    logic [1:0]          r_beat;
    logic [WORD_W-1:0]   r_word;     // word index; byte offset comes from r_beat
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata0;
    logic [31:0]         r_rdata1;

    logic                w_req_any;
    logic                w_win;
    logic                w_win_we;
    logic [31:0]         w_win_addr;
    logic [31:0]         w_win_wdata;
    logic                w_bad;
    logic                w_grant;
    logic                w_xfer;
    logic                w_resp;

    // ---------------- arbitration and address check ----------------
    always_comb begin
        w_req_any   = io_bus.req0 | io_bus.req1;
        // a lone requester wins outright; a tie goes to the rr port
        w_win       = (io_bus.req0 & io_bus.req1) ? r_rr : io_bus.req1;
        w_win_we    = w_win ? io_bus.we1    : io_bus.we0;
        w_win_addr  = w_win ? io_bus.addr1  : io_bus.addr0;
        w_win_wdata = w_win ? io_bus.wdata1 : io_bus.wdata0;
        // misaligned or beyond the memory: rejected without touching memory
        w_bad       = (w_win_addr[1:0] != 2'b00) |
                      (w_win_addr[31:MEM_ADDR_W] != '0);
    end

    assign w_grant = (r_state == ST_IDLE) & w_req_any;
    assign w_xfer  = (r_state == ST_XFER);
    assign w_resp  = (r_state == ST_RESP);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = w_bad ? ST_RESP : ST_XFER;
                end
            end
            ST_XFER: begin
                if (r_beat == 2'd3) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- transaction context and read assembly ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr     <= 1'b0;
            r_id     <= 1'b0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_beat   <= 2'd0;
            r_word   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_grant) begin
            r_id    <= w_win;
            r_rr    <= ~w_win;
            r_we    <= w_win_we;
            r_err   <= w_bad;
            r_beat  <= 2'd0;
            r_word  <= w_win_addr[MEM_ADDR_W-1:2];
            r_wdata <= w_win_wdata;
        end else if (w_xfer) begin
            // wraps back to 0 after beat 3, ready for the next grant
            r_beat <= r_beat + 2'd1;
            // little-endian: beat k fills byte lane k of the owner's rdata
            if (!r_we) begin
                if (r_id) begin
                    r_rdata1[{r_beat, 3'b000} +: 8] <= io_bus.mem_rdata;
                end else begin
                    r_rdata0[{r_beat, 3'b000} +: 8] <= io_bus.mem_rdata;
                end
            end
        end
    end

    // ---------------- outputs: pure decode of registered state ----------------
    always_comb begin
        io_bus.ack0      = w_resp & ~r_id;
        io_bus.ack1      = w_resp &  r_id;
        io_bus.err0      = w_resp & ~r_id & r_err;
        io_bus.err1      = w_resp &  r_id & r_err;
        io_bus.rdata0    = r_rdata0;
        io_bus.rdata1    = r_rdata1;
        io_bus.mem_addr  = '0;
        io_bus.mem_wdata = 8'h00;
        io_bus.mem_we    = 1'b0;
        io_bus.mem_re    = 1'b0;
        if (w_xfer) begin
            io_bus.mem_addr  = {r_word, r_beat};
            io_bus.mem_wdata = r_wdata[{r_beat, 3'b000} +: 8];
            io_bus.mem_we    = r_we;
            io_bus.mem_re    = ~r_we;
        end
        o_busy = (r_state != ST_IDLE);
    end

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Purpose : self-checking bench for mips_dmem_arbiter: transaction-level model plus directed scenarios.
// Latency : n/a.
// Backpressure: bench requesters hold req until ack, then drop it.
module tb_mips_dmem_arbiter;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    mips_dmem_arbiter_if #(.MEM_ADDR_W(AW)) bus ();

    mips_dmem_arbiter #(.MEM_ADDR_W(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    // ---------------- byte memory fixture ----------------
    logic [7:0] phys [1024];
    bit         written [1024];

    function automatic logic [7:0] init_byte(int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_byte(int a);
        return written[a] ? phys[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) begin
            phys[bus.mem_addr]    <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
    end

    assign bus.mem_rdata = written[bus.mem_addr] ? phys[bus.mem_addr]
                                                 : init_byte(int'(bus.mem_addr));

    // ---------------- check bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int ack_log [$];
    int ack_cyc [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_act;
    bit          m_rr;
    bit          m_id;
    bit          m_we;
    bit          m_bad;
    int          m_cyc;       // cycles since grant; 1 = first cycle after the grant edge
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata [2];
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_word(int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return {init_byte(a + 3), init_byte(a + 2), init_byte(a + 1), init_byte(a)};
    endfunction

    initial begin
        bit          w;
        int          last;
        int          beat;
        bit          e_xfer;
        bit          e_ack;
        logic [9:0]  e_addr;
        logic [7:0]  e_wdat;
        m_act = 0; m_rr = 0; m_cyc = 0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_act = 0; m_rr = 0;
                m_rdata[0] = '0; m_rdata[1] = '0;
            end else if (m_act) begin
                last = m_bad ? 1 : 5;
                if (m_cyc == last) m_act = 0;
                else m_cyc++;
            end else if (bus.req0 || bus.req1) begin
                w       = (bus.req0 && bus.req1) ? m_rr : bus.req1;
                m_rr    = !w;
                m_id    = w;
                m_we    = w ? bus.we1    : bus.we0;
                m_addr  = w ? bus.addr1  : bus.addr0;
                m_wdata = w ? bus.wdata1 : bus.wdata0;
                m_bad   = (m_addr % 4 != 0) || (m_addr >= 32'd1024);
                m_act   = 1;
                m_cyc   = 1;
            end
            last = m_bad ? 1 : 5;
            // a word's effect becomes architecturally visible in its ack cycle
            if (m_act && m_cyc == last && !m_bad) begin
                if (m_we) ref_mem[int'(m_addr)] = m_wdata;
                else m_rdata[m_id] = ref_word(int'(m_addr));
            end
            #2;
            e_xfer = m_act && !m_bad && m_cyc <= 4;
            e_ack  = m_act && m_cyc == last;
            beat   = m_cyc - 1;
            e_addr = e_xfer ? (m_addr[9:0] + 10'(beat)) : 10'd0;
            e_wdat = e_xfer ? 8'(m_wdata >> (8 * beat)) : 8'h00;
            chk("busy",   busy,          m_act);
            chk("mem_we", bus.mem_we,    e_xfer && m_we);
            chk("mem_re", bus.mem_re,    e_xfer && !m_we);
            chk("mem_addr", bus.mem_addr, e_addr);
            if (!e_xfer || m_we) chk("mem_wdata", bus.mem_wdata, e_wdat);
            chk("ack0", bus.ack0, e_ack && m_id == 0);
            chk("ack1", bus.ack1, e_ack && m_id == 1);
            chk("err0", bus.err0, e_ack && m_id == 0 && m_bad);
            chk("err1", bus.err1, e_ack && m_id == 1 && m_bad);
            // the owner's rdata fills byte by byte during a read; compare it elsewhere
            if (!(e_xfer && !m_we && m_id == 0)) chk("rdata0", bus.rdata0, m_rdata[0]);
            if (!(e_xfer && !m_we && m_id == 1)) chk("rdata1", bus.rdata1, m_rdata[1]);
            if (bus.ack0) begin ack_log.push_back(0); ack_cyc.push_back(cyc); end
            if (bus.ack1) begin ack_log.push_back(1); ack_cyc.push_back(cyc); end
        end
    end

    // ---------------- requester helpers ----------------
    task automatic drive(input int p, input bit r, input bit we, input logic [31:0] a,
                         input logic [31:0] wd);
        if (p == 0) begin bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; end
        else        begin bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; end
    endtask

    task automatic do_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output int lat);
        int t0;
        @(negedge clk);
        drive(p, 1'b1, we, a, wd);
        t0 = cyc; lat = -1; rd = '0; er = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((p == 0) ? bus.ack0 : bus.ack1) begin
                lat = cyc - t0;
                rd  = (p == 0) ? bus.rdata0 : bus.rdata1;
                er  = (p == 0) ? bus.err0   : bus.err1;
                break;
            end
        end
        if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    endtask

    task automatic wait_acks(input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (ack_log.size() >= target) break;
            @(negedge clk);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] rd;
        bit          er;
        int          lat;
        int          b;
        int          t0;

        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy",  busy,         32'd0);
        chk("rst_ack0",  bus.ack0,     32'd0);
        chk("rst_memwe", bus.mem_we,   32'd0);
        chk("rst_rd1",   bus.rdata1,   32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle with no requests
        repeat (8) @(negedge clk);
        chk("idle_busy", busy,       32'd0);
        chk("idle_re",   bus.mem_re, 32'd0);

        // port 0 write then read of 0x10
        do_req(0, 1'b1, 32'h10, 32'hA1B2C3D4, rd, er, lat);
        chk("wr_lat",  lat, 32'd5);
        chk("wr_err",  er,  32'd0);
        chk("wr_b10",  mem_byte(32'h10), 32'hD4);
        chk("wr_b11",  mem_byte(32'h11), 32'hC3);
        chk("wr_b12",  mem_byte(32'h12), 32'hB2);
        chk("wr_b13",  mem_byte(32'h13), 32'hA1);
        do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("rd_lat",  lat, 32'd5);
        chk("rd_data", rd,  32'hA1B2C3D4);

        // port 1 read of untouched memory, then two rejected reads
        do_req(1, 1'b0, 32'h100, 32'h0, rd, er, lat);
        chk("rd1_data", rd, 32'h59585B5A);
        do_req(1, 1'b0, 32'h2, 32'h0, rd, er, lat);
        chk("mis_lat", lat, 32'd1);
        chk("mis_err", er,  32'd1);
        chk("mis_rd",  rd,  32'h59585B5A);
        do_req(1, 1'b0, 32'h400, 32'h0, rd, er, lat);
        chk("oor_lat", lat, 32'd1);
        chk("oor_err", er,  32'd1);
        chk("oor_rd",  rd,  32'h59585B5A);

        // fairness: both held continuously
        @(negedge clk);
        b = ack_log.size();
        drive(0, 1'b1, 1'b0, 32'h10, '0);
        drive(1, 1'b1, 1'b0, 32'h100, '0);
        wait_acks(b + 4, 60);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        chk("fair_cnt", ack_log.size() - b, 32'd4);
        if (ack_log.size() >= b + 4) begin
            for (int k = 0; k < 4; k++) chk("fair_order", ack_log[b + k], k % 2);
            for (int k = 1; k < 4; k++) chk("fair_gap", ack_cyc[b + k] - ack_cyc[b + k - 1], 32'd6);
        end

        // early drop of req0 during transfer
        @(negedge clk);
        b = ack_log.size();
        drive(0, 1'b1, 1'b1, 32'h40, 32'h33221100);
        t0 = cyc;
        repeat (2) @(negedge clk);
        bus.req0 = 1'b0;
        wait_acks(b + 1, 15);
        chk("drop_lat", cyc - t0, 32'd5);
        repeat (10) @(negedge clk);
        chk("drop_acks", ack_log.size() - b, 32'd1);
        chk("drop_busy", busy, 32'd0);
        chk("drop_b43",  mem_byte(32'h43), 32'h33);

        // reset during beat 2 of a write
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        b = ack_log.size();
        rst_n = 1'b0;
        bus.req0 = 1'b0;
        #1;
        chk("mr_busy",  busy,          32'd0);
        chk("mr_we",    bus.mem_we,    32'd0);
        chk("mr_addr",  bus.mem_addr,  32'd0);
        chk("mr_wdata", bus.mem_wdata, 32'd0);
        chk("mr_rd0",   bus.rdata0,    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mr_noack", ack_log.size() - b, 32'd0);
        chk("mr_b20", mem_byte(32'h20), 32'hEF);
        chk("mr_b21", mem_byte(32'h21), 32'hBE);
        chk("mr_b22", mem_byte(32'h22), 32'h78);

        // after reset, a tie goes to port 0
        @(negedge clk);
        b = ack_log.size();
        drive(0, 1'b1, 1'b0, 32'h10, '0);
        drive(1, 1'b1, 1'b0, 32'h100, '0);
        wait_acks(b + 1, 20);
        bus.req0 = 1'b0;
        chk("pr_first_cnt", ack_log.size() - b, 32'd1);
        if (ack_log.size() > b) chk("pr_first_port", ack_log[b], 32'd0);
        chk("pr_rd0", bus.rdata0, 32'hA1B2C3D4);
        wait_acks(b + 2, 20);
        bus.req1 = 1'b0;
        chk("pr_second_cnt", ack_log.size() - b, 32'd2);
        chk("pr_rd1", bus.rdata1, 32'h59585B5A);

        repeat (10) @(negedge clk);
        chk("end_busy", busy, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
